expr_recognizer: RTL

- Character-serial recognizer for infix arithmetic expressions. It generalises the single-digit "d(op d)*" recognizer.
- Consumes one 8-bit ASCII character per cycle when in_valid is high.
- Supports multi-digit operands, the operators + - * /, and nested parentheses.
- Flags whether the prefix seen so far is a complete, well-formed expression. Sits behind the console/UART byte stream as a syntax checker.

---
 rtl/expr_pkg.sv | 33 +++
 rtl/expr_char_class.sv | 32 +++
 rtl/expr_recognizer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// expr_pkg: shared types and constants for the expression recognizer.
//   state_e : recognizer states (EXPECT_OPND=0, IN_NUM=1, AFTER_CLOSE=2, ERROR=3)
//   cls_e   : 3-bit character class codes produced by expr_char_class
//   CH_*    : ASCII constants for operators, parentheses, space and digit range
package expr_pkg;

  typedef enum logic [1:0] {
    EXPECT_OPND = 2'd0,
    IN_NUM      = 2'd1,
    AFTER_CLOSE = 2'd2,
    ERROR       = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_DIGIT = 3'd0,
    CLS_OP    = 3'd1,
    CLS_LPAR  = 3'd2,
    CLS_RPAR  = 3'd3,
    CLS_SPACE = 3'd4,
    CLS_OTHER = 3'd5
  } cls_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_LPAR  = 8'h28;
  localparam logic [7:0] CH_RPAR  = 8'h29;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

endpackage

// File: rtl/expr_char_class.sv
// expr_char_class: combinational ASCII character classifier.
//   ch  [7:0] : input character
//   cls       : class code (digit / op / lpar / rpar / space / other)
// Macro EXPR_SPACE_SKIP_EN: when defined, 0x20 is classified as CLS_SPACE;
// otherwise it is CLS_OTHER.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output cls_e       cls
);

  always_comb begin
    cls = CLS_OTHER;
    if (ch >= CH_ZERO && ch <= CH_NINE) begin
      cls = CLS_DIGIT;
    end else begin
      unique case (ch)
        CH_PLUS, CH_MINUS, CH_STAR, CH_SLASH: cls = CLS_OP;
        CH_LPAR:                              cls = CLS_LPAR;
        CH_RPAR:                              cls = CLS_RPAR;
`ifdef EXPR_SPACE_SKIP_EN
        CH_SPACE:                             cls = CLS_SPACE;
`else
        // space stays CLS_OTHER and is a syntax error
`endif
        default:                              cls = CLS_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/expr_recognizer.sv
// expr_recognizer: character-serial recognizer for infix arithmetic
// expressions with multi-digit operands, + - * / and nested parentheses.
//   clk      : clock, rising edge
//   clr_n    : asynchronous active-low reset
//   in       : ASCII character
//   in_valid : character qualifier; state held when low
//   out      : prefix so far is a complete, balanced expression (registered)
//   err      : sticky syntax error
//   depth    : current open-parenthesis count
//   operands : completed operand count, saturating
// Macro EXPR_SPACE_SKIP_EN: when defined, spaces are ignored except that a
// space inside a number terminates it.
module expr_recognizer
  import expr_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MAX_DEPTH  = 7,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic [7:0]                     in,
  input  logic                           in_valid,
  output logic                           out,
  output logic                           err,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic [CNT_W-1:0]               operands
);

  localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int unsigned DC_W    = $clog2(MAX_DIGITS + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DC_W-1:0]    DC_MAX    = DC_W'(MAX_DIGITS);

  cls_e               cls;
  state_e             state_q, state_d;
  logic [DC_W-1:0]    dcnt_q, dcnt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   opnds_q, opnds_d, opnds_inc;
  logic               out_q, out_d;

  expr_char_class u_class (
    .ch  (in),
    .cls (cls)
  );

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    depth_d   = depth_q;
    opnds_d   = opnds_q;
    opnds_inc = (opnds_q == '1) ? opnds_q : opnds_q + CNT_W'(1);

    if (in_valid) begin
      if (cls == CLS_SPACE) begin
        // A space ends a number by forcing the digit count to its limit,
        // so any further digit hits the overflow error path.
        if (state_q == IN_NUM) dcnt_d = DC_MAX;
      end else begin
        unique case (state_q)
          EXPECT_OPND: begin
            if (cls == CLS_DIGIT) begin
              state_d = IN_NUM;
              dcnt_d  = DC_W'(1);
            end else if (cls == CLS_LPAR && depth_q != DEPTH_MAX) begin
              depth_d = depth_q + DEPTH_W'(1);
            end else begin
              state_d = ERROR;
            end
          end
          IN_NUM: begin
            if (cls == CLS_DIGIT && dcnt_q != DC_MAX) begin
              dcnt_d = dcnt_q + DC_W'(1);
            end else if (cls == CLS_OP) begin
              opnds_d = opnds_inc;
              state_d = EXPECT_OPND;
            end else if (cls == CLS_RPAR && depth_q != '0) begin
              opnds_d = opnds_inc;
              depth_d = depth_q - DEPTH_W'(1);
              state_d = AFTER_CLOSE;
            end else begin
              state_d = ERROR;
            end
          end
          AFTER_CLOSE: begin
            if (cls == CLS_OP) begin
              state_d = EXPECT_OPND;
            end else if (cls == CLS_RPAR && depth_q != '0) begin
              depth_d = depth_q - DEPTH_W'(1);
            end else begin
              state_d = ERROR;
            end
          end
          ERROR: state_d = ERROR;
          default: state_d = ERROR;
        endcase
      end
    end

    out_d = (state_d == IN_NUM || state_d == AFTER_CLOSE) && depth_d == '0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= EXPECT_OPND;
      dcnt_q  <= '0;
      depth_q <= '0;
      opnds_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      depth_q <= depth_d;
      opnds_q <= opnds_d;
      out_q   <= out_d;
    end
  end

  assign out      = out_q;
  assign err      = (state_q == ERROR);
  assign depth    = depth_q;
  assign operands = opnds_q;

endmodule
